// File: rtl/biriscv_fetch_queue.sv
// -----------------------------------------------------------------------------
// biriscv_fetch_queue
//
// Instruction queue between fetch and the dual-issue decode path. A fetch
// packet carries LANES instructions sharing one PC. Only the lanes that will
// execute are written: lanes before the PC's start lane and lanes after a
// predicted-taken branch are dropped. Up to two in-order instructions are
// presented per cycle on out0/out1.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   fetch_in_*                fetch packet (valid, LANES instrs, PC, per-lane
//                             prediction, packet-wide fault flags)
//   fetch_in_accept_o         room for a full packet (registered count only)
//   flush_i                   empty the queue next cycle
//   fetch_out{0,1}_*          head and head+1 entries with valid/accept
//   count_o                   current occupancy
// -----------------------------------------------------------------------------
module biriscv_fetch_queue #(
  parameter int LANES     = 2,
  parameter int LANES_W   = 1,
  parameter int ENTRIES   = 8,
  parameter int ENTRIES_W = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    fetch_in_valid_i,
  input  logic [32*LANES-1:0]     fetch_in_instr_i,
  input  logic [31:0]             fetch_in_pc_i,
  input  logic [LANES-1:0]        fetch_in_pred_branch_i,
  input  logic                    fetch_in_fault_fetch_i,
  input  logic                    fetch_in_fault_page_i,
  output logic                    fetch_in_accept_o,
  input  logic                    flush_i,
  output logic                    fetch_out0_valid_o,
  output logic [31:0]             fetch_out0_instr_o,
  output logic [31:0]             fetch_out0_pc_o,
  output logic                    fetch_out0_pred_branch_o,
  output logic                    fetch_out0_fault_fetch_o,
  output logic                    fetch_out0_fault_page_o,
  input  logic                    fetch_out0_accept_i,
  output logic                    fetch_out1_valid_o,
  output logic [31:0]             fetch_out1_instr_o,
  output logic [31:0]             fetch_out1_pc_o,
  output logic                    fetch_out1_pred_branch_o,
  output logic                    fetch_out1_fault_fetch_o,
  output logic                    fetch_out1_fault_page_o,
  input  logic                    fetch_out1_accept_i,
  output logic [ENTRIES_W:0]      count_o
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
    logic        fault_fetch;
    logic        fault_page;
  } entry_t;

  entry_t                  mem_q [ENTRIES];
  logic [ENTRIES_W-1:0]    rd_ptr_q;
  logic [ENTRIES_W-1:0]    wr_ptr_q;
  logic [ENTRIES_W:0]      count_q;

  // ---------------------------------------------------------------------------
  // Lane selection
  // ---------------------------------------------------------------------------
  logic [LANES_W-1:0]          start_lane;
  logic                        fault_w;
  logic [LANES-1:0]            lane_valid;
  entry_t [LANES-1:0]          lane_entry;
  logic [LANES-1:0][ENTRIES_W-1:0] lane_addr;
  logic [ENTRIES_W:0]          push_cnt;
  logic                        lane_stop;
  logic                        unused_pc_lsbs;

  assign start_lane     = fetch_in_pc_i[LANES_W+1:2];
  assign fault_w        = fetch_in_fault_fetch_i | fetch_in_fault_page_i;
  assign unused_pc_lsbs = ^fetch_in_pc_i[1:0];

  // Valid lanes form one contiguous run starting at the start lane, so the
  // running count of earlier valid lanes is each lane's write offset.
  // A fault or a predicted-taken lane ends the run after that lane.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a value unassigned and a latch cannot be inferred.
    lane_valid = '0;
    lane_entry = '0;
    lane_addr  = '0;
    push_cnt   = '0;
    lane_stop  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_entry[i].instr       = fetch_in_instr_i[32*i +: 32];
      lane_entry[i].pc          = {fetch_in_pc_i[31:LANES_W+2], LANES_W'(i), 2'b00};
      lane_entry[i].pred        = fetch_in_pred_branch_i[i] & ~fault_w;
      lane_entry[i].fault_fetch = fetch_in_fault_fetch_i;
      lane_entry[i].fault_page  = fetch_in_fault_page_i;
      lane_addr[i]              = wr_ptr_q + push_cnt[ENTRIES_W-1:0];
      if ((LANES_W'(i) >= start_lane) && !lane_stop) begin
        lane_valid[i] = 1'b1;
        push_cnt      = push_cnt + (ENTRIES_W+1)'(1);
        if (fetch_in_pred_branch_i[i] || fault_w)
          lane_stop = 1'b1;
      end
    end
  end

  // Room is judged on the registered count only; a same-cycle pop never
  // creates space, which keeps accept_o free of any path from accept_i.
  assign fetch_in_accept_o = (count_q <= (ENTRIES_W+1)'(ENTRIES - LANES));

  logic push;
  assign push = fetch_in_valid_i & fetch_in_accept_o & ~flush_i;

  // ---------------------------------------------------------------------------
  // Output slots and pop
  // ---------------------------------------------------------------------------
  logic [ENTRIES_W-1:0] rd_ptr_nxt;
  entry_t               head0;
  entry_t               head1;
  logic                 pop0;
  logic                 pop1;
  logic [ENTRIES_W:0]   pop_cnt;

  assign rd_ptr_nxt = rd_ptr_q + ENTRIES_W'(1);
  assign head0      = mem_q[rd_ptr_q];
  assign head1      = mem_q[rd_ptr_nxt];

  assign fetch_out0_valid_o       = (count_q != '0);
  assign fetch_out1_valid_o       = (count_q > (ENTRIES_W+1)'(1));
  assign fetch_out0_instr_o       = head0.instr;
  assign fetch_out0_pc_o          = head0.pc;
  assign fetch_out0_pred_branch_o = head0.pred;
  assign fetch_out0_fault_fetch_o = head0.fault_fetch;
  assign fetch_out0_fault_page_o  = head0.fault_page;
  assign fetch_out1_instr_o       = head1.instr;
  assign fetch_out1_pc_o          = head1.pc;
  assign fetch_out1_pred_branch_o = head1.pred;
  assign fetch_out1_fault_fetch_o = head1.fault_fetch;
  assign fetch_out1_fault_page_o  = head1.fault_page;
  assign count_o                  = count_q;

  // Slot 1 may only leave together with slot 0 so order is preserved.
  assign pop0    = fetch_out0_accept_i & fetch_out0_valid_o;
  assign pop1    = fetch_out1_accept_i & fetch_out1_valid_o & fetch_out0_accept_i;
  assign pop_cnt = pop1 ? (ENTRIES_W+1)'(2) : (pop0 ? (ENTRIES_W+1)'(1) : '0);

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: the storage array is reset as well, so data outputs read as
      // zero after reset; a flush deliberately leaves it untouched.
      for (int e = 0; e < ENTRIES; e++)
        mem_q[e] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < LANES; i++)
          if (lane_valid[i])
            mem_q[lane_addr[i]] <= lane_entry[i];
        wr_ptr_q <= wr_ptr_q + push_cnt[ENTRIES_W-1:0];
      end
      rd_ptr_q <= rd_ptr_q + pop_cnt[ENTRIES_W-1:0];
      count_q  <= count_q + (push ? push_cnt : '0) - pop_cnt;
    end
  end

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
module tb_biriscv_fetch_queue;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pc;
  logic        ff;
  logic        fp;

  // LANES=2 instance signals
  logic        v2, acc2, a0_2, a1_2;
  logic [63:0] instr2;
  logic [1:0]  pred2;
  logic        o2_v0, o2_v1, o2_b0, o2_b1, o2_ff0, o2_ff1, o2_fp0, o2_fp1;
  logic [31:0] o2_i0, o2_i1, o2_p0, o2_p1;
  logic [3:0]  cnt2;

  // LANES=4 instance signals
  logic         v4, acc4, a0_4, a1_4;
  logic [127:0] instr4;
  logic [3:0]   pred4;
  logic         o4_v0, o4_v1, o4_b0, o4_b1, o4_ff0, o4_ff1, o4_fp0, o4_fp1;
  logic [31:0]  o4_i0, o4_i1, o4_p0, o4_p1;
  logic [3:0]   cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  biriscv_fetch_queue #(.LANES(2), .LANES_W(1), .ENTRIES(8), .ENTRIES_W(3)) u2 (
    .clk_i(clk), .rst_i(rst),
    .fetch_in_valid_i(v2), .fetch_in_instr_i(instr2), .fetch_in_pc_i(pc),
    .fetch_in_pred_branch_i(pred2), .fetch_in_fault_fetch_i(ff),
    .fetch_in_fault_page_i(fp), .fetch_in_accept_o(acc2), .flush_i(flush),
    .fetch_out0_valid_o(o2_v0), .fetch_out0_instr_o(o2_i0), .fetch_out0_pc_o(o2_p0),
    .fetch_out0_pred_branch_o(o2_b0), .fetch_out0_fault_fetch_o(o2_ff0),
    .fetch_out0_fault_page_o(o2_fp0), .fetch_out0_accept_i(a0_2),
    .fetch_out1_valid_o(o2_v1), .fetch_out1_instr_o(o2_i1), .fetch_out1_pc_o(o2_p1),
    .fetch_out1_pred_branch_o(o2_b1), .fetch_out1_fault_fetch_o(o2_ff1),
    .fetch_out1_fault_page_o(o2_fp1), .fetch_out1_accept_i(a1_2),
    .count_o(cnt2)
  );

  biriscv_fetch_queue #(.LANES(4), .LANES_W(2), .ENTRIES(8), .ENTRIES_W(3)) u4 (
    .clk_i(clk), .rst_i(rst),
    .fetch_in_valid_i(v4), .fetch_in_instr_i(instr4), .fetch_in_pc_i(pc),
    .fetch_in_pred_branch_i(pred4), .fetch_in_fault_fetch_i(ff),
    .fetch_in_fault_page_i(fp), .fetch_in_accept_o(acc4), .flush_i(flush),
    .fetch_out0_valid_o(o4_v0), .fetch_out0_instr_o(o4_i0), .fetch_out0_pc_o(o4_p0),
    .fetch_out0_pred_branch_o(o4_b0), .fetch_out0_fault_fetch_o(o4_ff0),
    .fetch_out0_fault_page_o(o4_fp0), .fetch_out0_accept_i(a0_4),
    .fetch_out1_valid_o(o4_v1), .fetch_out1_instr_o(o4_i1), .fetch_out1_pc_o(o4_p1),
    .fetch_out1_pred_branch_o(o4_b1), .fetch_out1_fault_fetch_o(o4_ff1),
    .fetch_out1_fault_page_o(o4_fp1), .fetch_out1_accept_i(a1_4),
    .count_o(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a LANES=2 packet whose lane instruction is its lane PC xor K.
  task automatic drive2(input logic [31:0] p);
    logic [31:0] base;
    base   = {p[31:3], 3'b000};
    pc     = p;
    instr2 = {(base + 32'd4) ^ K, base ^ K};
    v2     = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; pc = '0; ff = 1'b0; fp = 1'b0;
    v2 = 1'b0; instr2 = '0; pred2 = '0; a0_2 = 1'b0; a1_2 = 1'b0;
    v4 = 1'b0; pred4 = '0; a0_4 = 1'b0; a1_4 = 1'b0;
    instr4 = {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
    tick(); tick();

    // Reset state
    check("rst_v0", o2_v0, 0);
    check("rst_v1", o2_v1, 0);
    check("rst_cnt", cnt2, 0);
    check("rst_acc", acc2, 1);
    check("rst_i0", o2_i0, 0);
    check("rst_p1", o2_p1, 0);
    rst = 1'b0;

    // Full packet, visible next cycle
    pc = 32'h1000; instr2 = {32'hBBBB_BBBB, 32'hAAAA_AAAA}; v2 = 1'b1;
    tick(); v2 = 1'b0;
    check("full_v0", o2_v0, 1);
    check("full_i0", o2_i0, 32'hAAAA_AAAA);
    check("full_p0", o2_p0, 32'h1000);
    check("full_v1", o2_v1, 1);
    check("full_i1", o2_i1, 32'hBBBB_BBBB);
    check("full_p1", o2_p1, 32'h1004);
    check("full_cnt", cnt2, 2);

    // out1 accept alone pops nothing
    a1_2 = 1'b1;
    tick(); a1_2 = 1'b0;
    check("a1only_cnt", cnt2, 2);
    check("a1only_i0", o2_i0, 32'hAAAA_AAAA);

    // Single pops down to empty
    a0_2 = 1'b1;
    tick();
    check("pop1_cnt", cnt2, 1);
    check("pop1_p0", o2_p0, 32'h1004);
    check("pop1_v1", o2_v1, 0);
    tick(); a0_2 = 1'b0;
    check("empty_cnt", cnt2, 0);
    check("empty_v0", o2_v0, 0);

    // Fill without accepts: 1 + 2 + 2 + 2 lanes
    drive2(32'h1104); tick();
    check("fill1_cnt", cnt2, 1);
    check("fill1_p0", o2_p0, 32'h1104);
    drive2(32'h1108); tick();
    drive2(32'h1110); tick();
    check("fill5_cnt", cnt2, 5);
    check("fill5_acc", acc2, 1);
    drive2(32'h1118); tick();
    check("fill7_cnt", cnt2, 7);
    check("fill7_acc", acc2, 0);
    drive2(32'h1120); tick(); v2 = 1'b0;
    check("stall_cnt", cnt2, 7);

    // Pop one to reach 6, then push 2 and pop 2 together
    a0_2 = 1'b1; tick();
    check("at6_cnt", cnt2, 6);
    check("at6_acc", acc2, 1);
    check("at6_p0", o2_p0, 32'h1108);
    a1_2 = 1'b1; drive2(32'h1120); tick(); v2 = 1'b0;
    check("pp_cnt", cnt2, 6);
    check("pp_p0", o2_p0, 32'h1110);
    check("pp_p1", o2_p1, 32'h1114);

    // Drain across the wrap, out1 reading index 0 while out0 is at index 7
    tick();
    check("wrap_p0", o2_p0, 32'h1118);
    check("wrap_p1", o2_p1, 32'h111C);
    check("wrap_i1", o2_i1, 32'h111C ^ K);
    check("wrap_cnt", cnt2, 4);
    tick();
    check("wrap2_p0", o2_p0, 32'h1120);
    check("wrap2_i1", o2_i1, 32'h1124 ^ K);
    tick(); a0_2 = 1'b0; a1_2 = 1'b0;
    check("drain_cnt", cnt2, 0);
    check("drain_v0", o2_v0, 0);

    // Flush overrides push and pop in the same cycle
    drive2(32'h1200); tick();
    check("prefl_cnt", cnt2, 2);
    drive2(32'h1208); a0_2 = 1'b1; a1_2 = 1'b1; flush = 1'b1;
    tick(); v2 = 1'b0; a0_2 = 1'b0; a1_2 = 1'b0; flush = 1'b0;
    check("flush_cnt", cnt2, 0);
    check("flush_v0", o2_v0, 0);
    check("flush_v1", o2_v1, 0);
    check("flush_acc", acc2, 1);

    // Predicted-taken lane 0 drops lane 1
    drive2(32'h1300); pred2 = 2'b01; tick(); v2 = 1'b0; pred2 = '0;
    check("pred2_cnt", cnt2, 1);
    check("pred2_b0", o2_b0, 1);
    check("pred2_p0", o2_p0, 32'h1300);
    flush = 1'b1; tick(); flush = 1'b0;

    // LANES=4: mid-packet entry and predicted exit
    pc = 32'h2004; pred4 = 4'b0100; v4 = 1'b1;
    tick(); v4 = 1'b0; pred4 = '0;
    check("mid_cnt", cnt4, 2);
    check("mid_p0", o4_p0, 32'h2004);
    check("mid_i0", o4_i0, 32'h4000_0001);
    check("mid_b0", o4_b0, 0);
    check("mid_p1", o4_p1, 32'h2008);
    check("mid_i1", o4_i1, 32'h4000_0002);
    check("mid_b1", o4_b1, 1);

    // LANES=4 full boundary: count 6 > 4 blocks input
    pc = 32'h2010; v4 = 1'b1; tick(); v4 = 1'b0;
    check("f4_cnt", cnt4, 6);
    check("f4_acc", acc4, 0);
    a0_4 = 1'b1; a1_4 = 1'b1; tick(); a0_4 = 1'b0; a1_4 = 1'b0;
    check("f4pop_cnt", cnt4, 4);
    check("f4pop_acc", acc4, 1);
    check("f4pop_p0", o4_p0, 32'h2010);
    check("f4pop_i0", o4_i0, 32'h4000_0000);
    flush = 1'b1; tick(); flush = 1'b0;

    // Fault packet: only the start lane, pred forced low
    pc = 32'h3008; fp = 1'b1; pred4 = 4'b0100; v4 = 1'b1;
    tick(); v4 = 1'b0; fp = 1'b0; pred4 = '0;
    check("flt_cnt", cnt4, 1);
    check("flt_p0", o4_p0, 32'h3008);
    check("flt_i0", o4_i0, 32'h4000_0002);
    check("flt_fp0", o4_fp0, 1);
    check("flt_ff0", o4_ff0, 0);
    check("flt_b0", o4_b0, 0);
    check("flt_v1", o4_v1, 0);

    // Reset mid-stream wins over a pending push
    pc = 32'h3000; v4 = 1'b1; rst = 1'b1;
    tick(); v4 = 1'b0; rst = 1'b0;
    check("rstm_cnt", cnt4, 0);
    check("rstm_v0", o4_v0, 0);
    check("rstm_acc", acc4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
